// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file defaults and the zero-register address test
package rf_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_REG   = 31;
  function automatic logic zero_hit(input int addr, input bit has_zero, input int zero_reg);
    return has_zero && (addr == zero_reg);
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus into the register file and its scoreboard
interface regfile_scoreboard_if import rf_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] RA, RB, RW, RD;
  logic [DATA_WIDTH-1:0] BusA, BusB, BusW;
  logic                  RegWr, Issue, UseA, UseB;
  logic                  ReadyA, ReadyB, Stall;
  logic [ADDR_WIDTH:0]   BusyCount;
  modport master (
    output RA, RB, RW, BusW, RegWr, Issue, RD, UseA, UseB,
    input  BusA, BusB, ReadyA, ReadyB, Stall, BusyCount
  );
  modport slave (
    input  RA, RB, RW, BusW, RegWr, Issue, RD, UseA, UseB,
    output BusA, BusB, ReadyA, ReadyB, Stall, BusyCount
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, running busy count and operand readiness
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit HAS_ZERO   = 1'b1,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Resetb,
  input  logic [ADDR_WIDTH-1:0] i_ra,
  input  logic [ADDR_WIDTH-1:0] i_rb,
  input  logic [ADDR_WIDTH-1:0] i_rw,
  input  logic                  i_regwr,
  input  logic                  i_issue,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  output logic                  o_ready_a,
  output logic                  o_ready_b,
  output logic [ADDR_WIDTH:0]   o_busy_count
);
  localparam int NREGS = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_iss, w_inc, w_dec;
  assign w_wr  = i_regwr && !zero_hit(int'(i_rw), HAS_ZERO, ZERO_REG);
  assign w_iss = i_issue && !zero_hit(int'(i_rd), HAS_ZERO, ZERO_REG);
  // A write clearing a bit that the same edge re-issues leaves it busy, so it must not decrement.
  assign w_inc = w_iss && !r_busy[i_rd];
  assign w_dec = w_wr && r_busy[i_rw] && !(w_iss && (i_rd == i_rw));
  always_ff @(negedge Clk or negedge Resetb)
    if (!Resetb) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_busy[i_rw] <= 1'b0;
      if (w_iss) r_busy[i_rd] <= 1'b1;
      r_count <= r_count + CW'(w_inc) - CW'(w_dec);
    end
  assign o_ready_a = zero_hit(int'(i_ra), HAS_ZERO, ZERO_REG) || !r_busy[i_ra] ||
                     (BYPASS && i_regwr && (i_rw == i_ra));
  assign o_ready_b = zero_hit(int'(i_rb), HAS_ZERO, ZERO_REG) || !r_busy[i_rb] ||
                     (BYPASS && i_regwr && (i_rw == i_rb));
  assign o_busy_count = r_count;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R1W register file with zero register, write bypass and busy scoreboard
module regfile_scoreboard import rf_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit HAS_ZERO   = 1'b1,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter bit BYPASS     = 1'b1
) (
  input logic Clk,
  input logic Resetb,
  regfile_scoreboard_if.slave rf
);
  localparam int NREGS = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_regs [NREGS];
  logic                  w_wr, w_byp_a, w_byp_b, w_zero_a, w_zero_b;
  assign w_wr = rf.RegWr && !zero_hit(int'(rf.RW), HAS_ZERO, ZERO_REG);
  always_ff @(negedge Clk or negedge Resetb)
    if (!Resetb) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[rf.RW] <= rf.BusW;
    end
  assign w_zero_a = zero_hit(int'(rf.RA), HAS_ZERO, ZERO_REG);
  assign w_zero_b = zero_hit(int'(rf.RB), HAS_ZERO, ZERO_REG);
  assign w_byp_a  = BYPASS && rf.RegWr && (rf.RW == rf.RA);
  assign w_byp_b  = BYPASS && rf.RegWr && (rf.RW == rf.RB);
  // Zero register wins over bypass so XZR reads 0 even while being "written".
  assign rf.BusA = w_zero_a ? '0 : w_byp_a ? rf.BusW : r_regs[rf.RA];
  assign rf.BusB = w_zero_b ? '0 : w_byp_b ? rf.BusW : r_regs[rf.RB];
  rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .HAS_ZERO  (HAS_ZERO),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_sb (
    .Clk         (Clk),
    .Resetb      (Resetb),
    .i_ra        (rf.RA),
    .i_rb        (rf.RB),
    .i_rw        (rf.RW),
    .i_regwr     (rf.RegWr),
    .i_issue     (rf.Issue),
    .i_rd        (rf.RD),
    .o_ready_a   (rf.ReadyA),
    .o_ready_b   (rf.ReadyB),
    .o_busy_count(rf.BusyCount)
  );
  assign rf.Stall = (rf.UseA && !rf.ReadyA) || (rf.UseB && !rf.ReadyB);
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the lab register file: 2**ADDR_WIDTH x DATA_WIDTH storage with two asynchronous read ports and one write port. Adds an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for the pipelined ARMv8 core. The decode stage issues destinations and queries operand readiness. Writeback clears busy and updates data.

Parameters:
DATA_WIDTH, 64, register width in bits
ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH
HAS_ZERO, 1, 1 = register ZERO_REG reads 0 and ignores writes/issues
ZERO_REG, 31, index of the zero register (XZR)
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
Clk  in  1  clock; all state updates on falling edge
Resetb  in  1  asynchronous active-low reset
RA  in  ADDR_WIDTH  read address A
RB  in  ADDR_WIDTH  read address B
BusA  out  DATA_WIDTH  read data A, combinational
BusB  out  DATA_WIDTH  read data B, combinational
RW  in  ADDR_WIDTH  write address
BusW  in  DATA_WIDTH  write data
RegWr  in  1  write enable; also clears busy[RW]
Issue  in  1  mark RD busy (a new producer is in flight)
RD  in  ADDR_WIDTH  destination being issued
UseA  in  1  operand A is consumed this cycle
UseB  in  1  operand B is consumed this cycle
ReadyA  out  1  operand A is valid
ReadyB  out  1  operand B is valid
Stall  out  1  hazard: decode must hold
BusyCount  out  ADDR_WIDTH+1  number of busy registers, registered

Behaviour:
- Clock and reset: one clock, Clk. Reset Resetb is asynchronous and active-low.
- Reset (Resetb=0, asynchronous, independent of Clk):
  - All registers = 0, all busy bits = 0, BusyCount = 0.
  - Resulting outputs: BusA = BusB = 0, ReadyA = ReadyB = 1, Stall = 0.
  - Reset asserted mid-operation discards pending writes and issues immediately.
- Write, on negedge Clk with Resetb=1: if RegWr and not (HAS_ZERO and RW==ZERO_REG), then regs[RW] <= BusW and busy[RW] <= 0.
- Issue, on negedge Clk: if Issue and not (HAS_ZERO and RD==ZERO_REG), then busy[RD] <= 1.
- Simultaneous write and issue to the same index: data is written and busy ends set (the new producer wins).
- Read port A (B identical with RB):
  - HAS_ZERO and RA==ZERO_REG -> BusA = 0.
  - else BYPASS and RegWr and RW==RA -> BusA = BusW.
  - else BusA = regs[RA].
  - Zero-register check has priority over bypass.
- Readiness:
  - ReadyA = zero-reg hit OR !busy[RA] OR (BYPASS and RegWr and RW==RA).
  - Stall = (UseA & !ReadyA) | (UseB & !ReadyB). Purely combinational; no latency.
- BusyCount: registered on negedge Clk. After every edge it equals the popcount of the new busy vector.
  - Implemented incrementally: +1 when an issue sets a clear bit, -1 when a write clears a set bit.
  - Same-index write+issue on an already-busy register: net 0.
  - Range is 0..NREGS-1 with HAS_ZERO, 0..NREGS without; never wraps.
- RegWr to a non-busy register is legal: data updates, busy stays 0.
- Issue to an already-busy register: no change.
- X on unused address inputs while enables are low must not disturb state.

Decomposition:
- Package rf_pkg: default DATA_WIDTH/ADDR_WIDTH/ZERO_REG constants and a function zero_hit(addr).
- Sub-module rf_scoreboard: busy vector, BusyCount, readiness logic.
- Top level: storage array, read muxes/bypass, Stall.

Test Plan:
1. Reset check: pulse Resetb low between edges. Expect all 32 regs read 0, BusyCount=0, ReadyA=ReadyB=1 immediately without a Clk edge.
2. Zero-register writes ignored: RegWr=1, RW=31, BusW=64'h12345678, plus Issue with RD=31. After the edge, BusA(RA=31)=0, ReadyA=1, BusyCount=0.
3. Fill and readback: write reg i with value i for i=0..30. Then RA=10/RB=11 -> BusA=10, BusB=11. With RegWr=0, BusW=64'h1000, RW=1: reg 1 stays 1.
4. Bypass: RA=13, RW=13, BusW=64'hABCD, RegWr=1 before the edge -> BusA=64'hABCD combinationally. With BYPASS=0 the same stimulus gives BusA=13 until the edge.
5. Scoreboard: Issue RD=5, edge -> BusyCount=1. RA=5, UseA=1 -> ReadyA=0, Stall=1. Then RegWr RW=5 BusW=64'h55 -> Stall=0 in the same cycle (bypass). After the edge, BusyCount=0 and BusA=64'h55.
6. Simultaneous events and mid-operation reset:
   - Busy reg 7; same edge Issue RD=7 and RegWr RW=7 BusW=9 -> regs[7]=9, busy[7]=1, BusyCount unchanged.
   - Assert Resetb with 3 registers busy -> BusyCount=0 and Stall=0 at once.
